// File: rtl/uart_pkg.sv
// Shared UART definitions used by the transmitter and, later, the receiver.
//   uart_state_e      : frame FSM state encoding
//   UART_DATA_BITS    : default data bits per frame
//   UART_CLKS_PER_BIT : default clk cycles per bit
//   parity_bit()      : even/odd parity of a zero-extended data word
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

  localparam int UART_DATA_BITS    = 8;
  localparam int UART_CLKS_PER_BIT = 1;

  // Unused upper bits must be zero, so callers pass a zero-extended word.
  function automatic logic parity_bit(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps on every bit boundary.
//   clk     : system clock
//   rst     : synchronous reset, active-high
//   clr     : synchronous clear, driven on FSM state changes
//   bit_end : high on the last cycle of the current bit
`timescale 1ns/1ps
module uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_end
);

  // A one-cycle bit still needs a 1-bit counter; it simply stays at 0.
  localparam int            CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  assign bit_end = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || clr || bit_end) cnt <= '0;
    else                       cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter with a one-byte holding register.
//   clk        : system clock
//   rst        : synchronous reset, active-high; aborts any frame
//   data_in    : byte to send, taken when data_valid && data_ready
//   data_valid : data_in is valid
//   data_ready : holding register empty (and not in reset)
//   Tx         : registered serial line, idles high
//   busy       : registered, high while a frame is on the line
//   tx_done    : high on the final cycle of the last stop bit
// Frame: start(0), DATA_BITS data LSB first, optional parity, STOP_BITS stop(1).
`timescale 1ns/1ps
module uart_tx import uart_pkg::*; #(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] data_in,
  input  logic                 data_valid,
  output logic                 data_ready,
  output logic                 Tx,
  output logic                 busy,
  output logic                 tx_done
);

  // idx counts data bits in DATA and stop bits in STOP.
  localparam int            IW        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_DATA = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] LAST_STOP = IW'(STOP_BITS - 1);

  uart_state_e          state, state_nxt;
  logic [DATA_BITS-1:0] hold, shift, shift_nxt;
  logic                 hold_full, par, accept, load, tx_nxt, bit_end;
  logic [IW-1:0]        idx;

  assign data_ready = !hold_full && !rst;
  assign accept     = data_valid && data_ready;

  uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_nxt != state),
    .bit_end (bit_end)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hold_full) state_nxt = START;
      START:   if (bit_end) state_nxt = DATA;
      DATA:    if (bit_end && idx == LAST_DATA) state_nxt = PARITY_EN ? PARITY : STOP;
      PARITY:  if (bit_end) state_nxt = STOP;
      STOP:    if (bit_end && idx == LAST_STOP) state_nxt = hold_full ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs / datapath control. Tx is registered, so it is computed from the
  // next state and next shift contents.
  always_comb begin
    load      = (state_nxt == START) && (state == IDLE || state == STOP);
    tx_done   = (state == STOP) && bit_end && (idx == LAST_STOP);
    shift_nxt = shift;
    if (load)
      shift_nxt = hold;
    else if (state == DATA && bit_end && idx != LAST_DATA)
      shift_nxt = shift >> 1;
    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par;
      default: tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold      <= '0;
      shift     <= '0;
      par       <= 1'b0;
      idx       <= '0;
      Tx        <= 1'b1;
      busy      <= 1'b0;
    end else begin
      shift <= shift_nxt;
      Tx    <= tx_nxt;
      busy  <= (state_nxt != IDLE);
      // accept and load are exclusive: accept needs an empty register,
      // load needs a full one.
      if (accept) begin
        hold      <= data_in;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
      // Parity is taken from the byte at load time, before it is shifted out.
      if (load) par <= parity_bit(32'(hold), PARITY_ODD);
      if (state_nxt != state)                            idx <= '0;
      else if (bit_end && (state == DATA || state == STOP)) idx <= idx + 1'b1;
    end
  end

endmodule
